// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// feeds the IF/ID register, inserting bubbles on redirects and on wait states.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    input  logic        imem_busywait,
    input  logic [31:0] imem_rdata,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out,
    output logic        busywait
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        FETCH      = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] target_aligned;

    assign target_aligned = {branch_target[31:2], 2'b00};
    assign imem_addr      = pc_q;
    assign PC_out         = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_HOLD;
            pc_q      <= RESET_PC;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pending_d       = pending_q;
        imem_read       = 1'b1;
        busywait        = 1'b0;
        instruction_out = NOP_INSTR;

        unique case (state_q)
            RESET_HOLD: begin
                imem_read = 1'b0;
                busywait  = 1'b1;
                state_d   = FETCH;
            end

            FETCH: begin
                if (branch_taken) begin
                    // Bubble goes downstream now; an in-flight read must
                    // complete before the PC may move, hence FLUSH.
                    if (imem_busywait) begin
                        pending_d = target_aligned;
                        state_d   = FLUSH;
                    end else begin
                        pc_d = target_aligned;
                    end
                end else begin
                    instruction_out = imem_rdata;
                    if (imem_busywait || stall) begin
                        busywait = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            FLUSH: begin
                if (branch_taken) begin
                    pending_d = target_aligned;
                end
                if (!imem_busywait) begin
                    pc_d    = branch_taken ? target_aligned : pending_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = RESET_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run compared against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_busywait;
    logic [31:0] imem_rdata;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic        busywait;

    int total = 0;
    int bad   = 0;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .stall           (stall),
        .imem_busywait   (imem_busywait),
        .imem_rdata      (imem_rdata),
        .imem_read       (imem_read),
        .imem_addr       (imem_addr),
        .instruction_out (instruction_out),
        .PC_out          (PC_out),
        .busywait        (busywait)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are looked at 1ns later.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        branch_taken  = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        imem_busywait = 1'b0;
        imem_rdata    = 32'h00A0_0093;
    endtask

    // Redirect the PC to addr with a clean single-cycle branch from FETCH.
    task automatic go_to(input logic [31:0] addr);
        idle_inputs();
        branch_taken  = 1'b1;
        branch_target = addr;
        next_cycle();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        @(negedge clk);
        #1;
        total++;
        if (imem_read !== 1'b0 || busywait !== 1'b1 || instruction_out !== NOP || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: read=%b bw=%b instr=%h addr=%h, want read=0 bw=1 instr=%h addr=0",
                     imem_read, busywait, instruction_out, imem_addr, NOP);
        end
        reset = 1'b0;
        #1;
        total++;
        if (imem_read !== 1'b0 || busywait !== 1'b1 || instruction_out !== NOP) begin
            bad++;
            $display("FAIL reset_hold: read=%b bw=%b instr=%h, want read=0 bw=1 instr=%h",
                     imem_read, busywait, instruction_out, NOP);
        end
        next_cycle();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (imem_addr !== 32'(i * 4) || busywait !== 1'b0 || imem_read !== 1'b1 ||
                instruction_out !== 32'h00A0_0093 || PC_out !== 32'(i * 4)) begin
                bad++;
                $display("FAIL seq_fetch%0d: addr=%h bw=%b read=%b instr=%h pc=%h, want addr=%h bw=0 read=1 instr=00a00093",
                         i, imem_addr, busywait, imem_read, instruction_out, PC_out, 32'(i * 4));
            end
            next_cycle();
        end
    endtask

    task automatic test_imem_wait();
        go_to(32'h10);
        imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (busywait !== 1'b1 || imem_addr !== 32'h10 || imem_read !== 1'b1) begin
                bad++;
                $display("FAIL wait_cycle%0d: bw=%b addr=%h read=%b, want bw=1 addr=10 read=1",
                         i, busywait, imem_addr, imem_read);
            end
            next_cycle();
        end
        imem_busywait = 1'b0;
        imem_rdata    = 32'h1234_5678;
        #1;
        total++;
        if (busywait !== 1'b0 || instruction_out !== 32'h1234_5678 || PC_out !== 32'h10) begin
            bad++;
            $display("FAIL wait_accept: bw=%b instr=%h pc=%h, want bw=0 instr=12345678 pc=10",
                     busywait, instruction_out, PC_out);
        end
        next_cycle();
        #1;
        total++;
        if (imem_addr !== 32'h14) begin
            bad++;
            $display("FAIL wait_next: addr=%h, want 14", imem_addr);
        end
    endtask

    task automatic test_branch_stall();
        go_to(32'h20);
        branch_taken  = 1'b1;
        branch_target = 32'h103;
        stall         = 1'b1;
        #1;
        total++;
        if (instruction_out !== NOP || busywait !== 1'b0 || imem_addr !== 32'h20) begin
            bad++;
            $display("FAIL branch_stall: instr=%h bw=%b addr=%h, want instr=%h bw=0 addr=20",
                     instruction_out, busywait, imem_addr, NOP);
        end
        next_cycle();
        idle_inputs();
        #1;
        total++;
        if (imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL branch_target_align: addr=%h, want 100", imem_addr);
        end
    endtask

    task automatic test_branch_flush();
        go_to(32'h40);
        // Redirect to 0x200 under a wait, re-redirect to 0x300, then two more wait cycles.
        for (int i = 0; i < 4; i++) begin
            branch_taken  = (i < 2);
            branch_target = (i == 0) ? 32'h200 : 32'h300;
            imem_busywait = (i < 3);
            imem_rdata    = 32'hDEAD_BEEF;
            #1;
            total++;
            if (instruction_out !== NOP || busywait !== 1'b0 || imem_addr !== 32'h40 || imem_read !== 1'b1) begin
                bad++;
                $display("FAIL flush_cycle%0d: instr=%h bw=%b addr=%h read=%b, want instr=%h bw=0 addr=40 read=1",
                         i, instruction_out, busywait, imem_addr, imem_read, NOP);
            end
            next_cycle();
        end
        idle_inputs();
        imem_rdata = 32'hCAFE_0001;
        #1;
        total++;
        if (imem_addr !== 32'h300 || instruction_out !== 32'hCAFE_0001 || busywait !== 1'b0) begin
            bad++;
            $display("FAIL flush_resume: addr=%h instr=%h bw=%b, want addr=300 instr=cafe0001 bw=0",
                     imem_addr, instruction_out, busywait);
        end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        total++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_start: addr=%h, want fffffffc", imem_addr);
        end
        next_cycle();
        #1;
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_next: addr=%h, want 0", imem_addr);
        end
    endtask

    task automatic test_reset_mid_flush();
        go_to(32'h80);
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        imem_busywait = 1'b1;
        next_cycle();
        branch_taken = 1'b0;
        #1;
        total++;
        if (instruction_out !== NOP || busywait !== 1'b0 || imem_read !== 1'b1 || imem_addr !== 32'h80) begin
            bad++;
            $display("FAIL pre_reset_flush: instr=%h bw=%b read=%b addr=%h, want NOP bw=0 read=1 addr=80",
                     instruction_out, busywait, imem_read, imem_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if (imem_read !== 1'b0 || busywait !== 1'b1 || instruction_out !== NOP || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_async: read=%b bw=%b instr=%h addr=%h, want read=0 bw=1 NOP addr=0",
                     imem_read, busywait, instruction_out, imem_addr);
        end
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        #1;
        total++;
        if (imem_read !== 1'b0 || busywait !== 1'b1) begin
            bad++;
            $display("FAIL reset_flush_hold: read=%b bw=%b, want read=0 bw=1", imem_read, busywait);
        end
        next_cycle();
        #1;
        total++;
        if (imem_read !== 1'b1 || imem_addr !== 32'h0 || busywait !== 1'b0) begin
            bad++;
            $display("FAIL reset_restart: read=%b addr=%h bw=%b, want read=1 addr=0 bw=0",
                     imem_read, imem_addr, busywait);
        end
    endtask

    // Model: the fetch address, whether a redirect is waiting on an in-flight
    // read, and the most recent redirect target. Starts in FETCH at PC 0.
    task automatic test_random();
        logic [31:0] m_pc;
        logic [31:0] m_redirect;
        logic        m_waiting;
        logic [31:0] exp_instr;
        logic        exp_bw;
        m_pc       = 32'h0;
        m_redirect = 32'h0;
        m_waiting  = 1'b0;
        for (int n = 0; n < 300; n++) begin
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            stall         = ($urandom_range(0, 3) == 0);
            imem_busywait = ($urandom_range(0, 1) == 0);
            imem_rdata    = $urandom;
            if (imem_rdata == NOP) imem_rdata = 32'h0;
            #1;
            if (m_waiting || branch_taken) begin
                exp_instr = NOP;
                exp_bw    = 1'b0;
            end else begin
                exp_instr = imem_rdata;
                exp_bw    = imem_busywait | stall;
            end
            total++;
            if (imem_addr !== m_pc || imem_read !== 1'b1 || imem_addr[1:0] !== 2'b00) begin
                bad++;
                $display("FAIL rand_addr[%0d]: addr=%h read=%b, want addr=%h read=1", n, imem_addr, imem_read, m_pc);
            end
            total++;
            if (instruction_out !== exp_instr || busywait !== exp_bw) begin
                bad++;
                $display("FAIL rand_out[%0d]: instr=%h bw=%b, want instr=%h bw=%b",
                         n, instruction_out, busywait, exp_instr, exp_bw);
            end
            if (exp_instr != NOP) begin
                total++;
                if (PC_out !== m_pc) begin
                    bad++;
                    $display("FAIL rand_pc[%0d]: pc=%h, want %h", n, PC_out, m_pc);
                end
            end
            if (branch_taken) m_redirect = branch_target & 32'hFFFF_FFFC;
            if (m_waiting || branch_taken) begin
                if (imem_busywait) begin
                    m_waiting = 1'b1;
                end else begin
                    m_pc      = m_redirect;
                    m_waiting = 1'b0;
                end
            end else if (!imem_busywait && !stall) begin
                m_pc = m_pc + 32'd4;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_imem_wait();
        test_branch_stall();
        test_branch_flush();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction driven downstream.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port branch_taken, input, 1 bit: redirect request from EX.
REQ-006 Port branch_target, input, 32 bits: redirect address.
REQ-007 Port stall, input, 1 bit: hazard stall from ID; holds PC.
REQ-008 Port imem_busywait, input, 1 bit: instruction memory not ready.
REQ-009 Port imem_rdata, input, 32 bits: instruction memory read data, valid when imem_busywait=0.
REQ-010 Port imem_read, output, 1 bit: instruction memory read request.
REQ-011 Port imem_addr, output, 32 bits: fetch address, always equal to the PC register.
REQ-012 Port instruction_out, output, 32 bits: instruction to the IF/ID register.
REQ-013 Port PC_out, output, 32 bits: address of instruction_out.
REQ-014 Port busywait, output, 1 bit: 1 = IF/ID register must hold its contents.

Function
REQ-015 The FSM SHALL have states RESET_HOLD, FETCH and FLUSH; RESET_HOLD SHALL last exactly one cycle, then go to FETCH.
REQ-016 In RESET_HOLD: imem_read=0, busywait=1, instruction_out=NOP_INSTR, PC held.
REQ-017 In FETCH and FLUSH, imem_read SHALL be 1; a request is never withdrawn while imem_busywait=1.
REQ-018 FETCH, branch_taken=0, imem_busywait=0, stall=0:
- instruction_out=imem_rdata, combinational, zero added latency.
- PC_out=PC, busywait=0.
- next PC=PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 FETCH, branch_taken=0, imem_busywait=1 or stall=1: busywait=1, PC held, instruction_out=imem_rdata.
REQ-020 FETCH, branch_taken=1, imem_busywait=0:
- instruction_out=NOP_INSTR, busywait=0 (bubble loaded).
- next PC={branch_target[31:2],2'b00}; state stays FETCH.
- branch_taken SHALL override stall.
REQ-021 FETCH, branch_taken=1, imem_busywait=1:
- latch {branch_target[31:2],2'b00} into pending_target; go to FLUSH.
- instruction_out=NOP_INSTR, busywait=0 in that cycle.
REQ-022 In FLUSH, each cycle:
- imem_addr held at the old PC; instruction_out=NOP_INSTR; busywait=0.
- returned data SHALL be discarded.
REQ-023 In FLUSH, a further branch_taken=1 SHALL overwrite pending_target (latest redirect wins).
REQ-024 In FLUSH, when imem_busywait=0: PC<=pending_target (or the concurrent branch_target if branch_taken=1 that cycle); go to FETCH.
REQ-025 PC_out SHALL equal PC whenever instruction_out is not NOP_INSTR; otherwise it is don't-care.
REQ-026 The PC SHALL never hold a value with bits [1:0] non-zero.

Reset
REQ-027 reset=1 SHALL asynchronously force PC=RESET_PC, pending_target=0, state=RESET_HOLD, imem_read=0, busywait=1, instruction_out=NOP_INSTR.
REQ-028 Reset asserted during FETCH or FLUSH SHALL abandon the outstanding request with no effect on post-reset state.
REQ-029 Fetch SHALL resume one cycle after reset deasserts.

Verification
REQ-030 Reset release, imem_busywait=0, rdata=0x00A00093 every cycle -> first fetch imem_addr=0x0, then 0x4, 0x8 on consecutive cycles; busywait=1 only in the RESET_HOLD cycle.
REQ-031 imem_busywait=1 for 3 cycles at PC=0x10 -> busywait=1, imem_addr=0x10 for 3 cycles; instruction accepted on the 4th; next imem_addr=0x14.
REQ-032 branch_taken=1, target=0x103, imem_busywait=0, stall=1 at PC=0x20 -> instruction_out=NOP, busywait=0; next imem_addr=0x100.
REQ-033 branch to 0x200 while imem_busywait=1 at PC=0x40, then branch to 0x300 next cycle, busywait drops after 2 more cycles -> NOPs throughout, imem_addr stays 0x40, then jumps to 0x300.
REQ-034 PC=0xFFFF_FFFC, no stall -> next imem_addr=0x0.
REQ-035 Assert reset mid-FLUSH -> immediate imem_read=0, busywait=1; fetch restarts at RESET_PC.
